// File: rtl/game_stats_pkg.sv
// Shared types and constants for the game statistics block and its BCD adder.
// Every counter is a packed BCD number; digit 0 is the least significant.
package game_stats_pkg;

  localparam int DIGITS = 6;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [DIGITS-1:0] bcd_num_t;

  typedef struct packed {
    bcd_num_t score;
    bcd_num_t lines;
    bcd_num_t level;
  } game_data_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCORE,
    ST_LINES
  } state_e;

  localparam bcd_num_t BASE_1  = 24'h000040;
  localparam bcd_num_t BASE_2  = 24'h000100;
  localparam bcd_num_t BASE_3  = 24'h000300;
  localparam bcd_num_t BASE_4  = 24'h001200;
  localparam bcd_num_t BCD_ONE = 24'h000001;
  localparam bcd_num_t BCD_MAX = 24'h999999;

  function automatic bcd_num_t score_base(input logic [2:0] n);
    case (n)
      3'd1:    score_base = BASE_1;
      3'd2:    score_base = BASE_2;
      3'd3:    score_base = BASE_3;
      3'd4:    score_base = BASE_4;
      default: score_base = '0;
    endcase
  endfunction

endpackage

// File: rtl/game_stats_if.sv
// Request/result bundle between the field logic (master) and game_stats (slave).
interface game_stats_if;
  import game_stats_pkg::*;

  logic       new_game_i;
  logic       lines_en_i;
  logic [2:0] lines_cnt_i;
  logic       ready_o;
  bcd_num_t   score_o;
  bcd_num_t   lines_o;
  bcd_num_t   level_o;
  logic       done_o;
  logic       level_up_o;

  modport master (
    output new_game_i, lines_en_i, lines_cnt_i,
    input  ready_o, score_o, lines_o, level_o, done_o, level_up_o
  );

  modport slave (
    input  new_game_i, lines_en_i, lines_cnt_i,
    output ready_o, score_o, lines_o, level_o, done_o, level_up_o
  );

endinterface

// File: rtl/game_stats_bcd_add.sv
// Combinational packed-BCD adder; sat_o flags a carry out of the top digit.
module game_stats_bcd_add
  import game_stats_pkg::*;
(
  input  bcd_num_t a_i,
  input  bcd_num_t b_i,
  output bcd_num_t sum_o,
  output logic     sat_o
);

  always_comb begin
    logic [4:0] s;
    logic       c;
    c     = 1'b0;
    s     = '0;
    sum_o = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, a_i[i]} + {1'b0, b_i[i]} + {4'd0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      sum_o[i] = s[3:0];
    end
    sat_o = c;
  end

endmodule

// File: rtl/game_stats.sv
// Score / lines / level counters for one game, updated over several cycles
// per "lines cleared" event; score is added once per current level.
module game_stats
  import game_stats_pkg::*;
#(
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 20
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  game_stats_if.slave  bus
);

  localparam logic [4:0] LPL  = 5'(LINES_PER_LEVEL);
  localparam logic [4:0] MAXL = 5'(MAX_LEVEL);

  state_e     state_q, state_d;
  logic [2:0] n_q, n_d;
  logic [4:0] iter_q, iter_d;
  logic [4:0] level_bin_q, level_bin_d;
  logic [3:0] lvl_lines_q, lvl_lines_d;
  bcd_num_t   score_q, score_d;
  bcd_num_t   lines_q, lines_d;
  bcd_num_t   level_q, level_d;
  bcd_num_t   level_inc_q, level_inc_d;
  logic       done_q, done_d;
  logic       level_up_q, level_up_d;

  bcd_num_t   score_sum, ll_a, ll_b, ll_sum;
  logic       score_sat, ll_sat;
  logic [4:0] lvl_sum;

  game_stats_bcd_add u_score_add (
    .a_i   (score_q),
    .b_i   (score_base(n_q)),
    .sum_o (score_sum),
    .sat_o (score_sat)
  );

  // Shared adder: precomputes level+1 while scoring, then adds n to lines.
  assign ll_a = (state_q == ST_LINES) ? lines_q : level_q;
  assign ll_b = (state_q == ST_LINES) ? bcd_num_t'({21'd0, n_q}) : BCD_ONE;

  game_stats_bcd_add u_ll_add (
    .a_i   (ll_a),
    .b_i   (ll_b),
    .sum_o (ll_sum),
    .sat_o (ll_sat)
  );

  assign lvl_sum = {1'b0, lvl_lines_q} + {2'd0, n_q};

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    iter_d      = iter_q;
    level_bin_d = level_bin_q;
    lvl_lines_d = lvl_lines_q;
    score_d     = score_q;
    lines_d     = lines_q;
    level_d     = level_q;
    level_inc_d = level_inc_q;
    done_d      = 1'b0;
    level_up_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.lines_en_i && bus.lines_cnt_i != 3'd0 && bus.lines_cnt_i <= 3'd4) begin
          n_d     = bus.lines_cnt_i;
          iter_d  = level_bin_q;
          state_d = ST_SCORE;
        end
      end
      ST_SCORE: begin
        score_d     = score_sat ? BCD_MAX : score_sum;
        iter_d      = iter_q - 5'd1;
        level_inc_d = ll_sum;
        if (iter_q == 5'd1) state_d = ST_LINES;
      end
      ST_LINES: begin
        lines_d = ll_sat ? BCD_MAX : ll_sum;
        if (lvl_sum >= LPL) begin
          lvl_lines_d = 4'(lvl_sum - LPL);
          if (level_bin_q < MAXL) begin
            level_bin_d = level_bin_q + 5'd1;
            level_d     = level_inc_q;
            level_up_d  = 1'b1;
          end
        end else begin
          lvl_lines_d = lvl_sum[3:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new game overrides everything, including an update in flight.
    if (bus.new_game_i) begin
      state_d     = ST_IDLE;
      n_d         = '0;
      iter_d      = '0;
      level_bin_d = 5'd1;
      lvl_lines_d = '0;
      score_d     = '0;
      lines_d     = '0;
      level_d     = BCD_ONE;
      level_inc_d = '0;
      done_d      = 1'b0;
      level_up_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      iter_q      <= '0;
      level_bin_q <= 5'd1;
      lvl_lines_q <= '0;
      score_q     <= '0;
      lines_q     <= '0;
      level_q     <= BCD_ONE;
      level_inc_q <= '0;
      done_q      <= 1'b0;
      level_up_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      iter_q      <= iter_d;
      level_bin_q <= level_bin_d;
      lvl_lines_q <= lvl_lines_d;
      score_q     <= score_d;
      lines_q     <= lines_d;
      level_q     <= level_d;
      level_inc_q <= level_inc_d;
      done_q      <= done_d;
      level_up_q  <= level_up_d;
    end
  end

  assign bus.ready_o    = (state_q == ST_IDLE);
  assign bus.score_o    = score_q;
  assign bus.lines_o    = lines_q;
  assign bus.level_o    = level_q;
  assign bus.done_o     = done_q;
  assign bus.level_up_o = level_up_q;

endmodule

// File: tb/tb_game_stats.sv
// Directed bench for game_stats: hand-computed vectors plus a small decimal
// reference model for the long climb to the level cap and score saturation.
module tb_game_stats;
  import game_stats_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_stats_if bus ();

  game_stats #(
    .LINES_PER_LEVEL (10),
    .MAX_LEVEL       (20)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   m_score, m_lines, m_level, m_lvl;
  logic m_lu;
  int   last_busy;
  logic last_lu;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int base_of(input int n);
    case (n)
      1: return 40;
      2: return 100;
      3: return 300;
      4: return 1200;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_score = 0;
    m_lines = 0;
    m_level = 1;
    m_lvl   = 0;
    m_lu    = 1'b0;
  endtask

  task automatic model_req(input int n);
    m_score = m_score + base_of(n) * m_level;
    if (m_score > 999999) m_score = 999999;
    m_lines = m_lines + n;
    m_lvl   = m_lvl + n;
    m_lu    = 1'b0;
    if (m_lvl >= 10) begin
      m_lvl = m_lvl - 10;
      if (m_level < 20) begin
        m_level = m_level + 1;
        m_lu    = 1'b1;
      end
    end
  endtask

  // Called just after the accepting edge; returns once done_o is seen.
  task automatic wait_done(input string tag);
    int guard;
    last_busy = 0;
    guard     = 0;
    while (bus.done_o !== 1'b1 && guard < 200) begin
      if (bus.ready_o === 1'b0) last_busy++;
      tick();
      guard++;
    end
    last_lu = bus.level_up_o;
    check({tag, "_done"}, {31'd0, bus.done_o}, 32'd1);
    check({tag, "_rdy_at_done"}, {31'd0, bus.ready_o}, 32'd1);
  endtask

  task automatic do_req(input int n, input string tag);
    int exp_busy;
    exp_busy = m_level + 1;
    model_req(n);
    bus.lines_en_i  = 1'b1;
    bus.lines_cnt_i = 3'(n);
    tick();
    bus.lines_en_i  = 1'b0;
    wait_done(tag);
    check({tag, "_busy"}, last_busy, exp_busy);
    check({tag, "_lu"}, {31'd0, last_lu}, {31'd0, m_lu});
    check({tag, "_score"}, bus.score_o, to_bcd(m_score));
    check({tag, "_lines"}, bus.lines_o, to_bcd(m_lines));
    check({tag, "_level"}, bus.level_o, to_bcd(m_level));
    tick();
    check({tag, "_done_1cyc"}, {31'd0, bus.done_o}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_cnt[3];
    int guard;
    bad_cnt = '{0, 5, 7};
    bus.new_game_i  = 1'b0;
    bus.lines_en_i  = 1'b0;
    bus.lines_cnt_i = 3'd0;

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
    check("rst_score", bus.score_o, 32'h000000);
    check("rst_lines", bus.lines_o, 32'h000000);
    check("rst_level", bus.level_o, 32'h000001);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("rst_done",  {31'd0, bus.done_o}, 32'd0);

    do_req(1, "first");
    check("first_score", bus.score_o, 32'h000040);
    check("first_lines", bus.lines_o, 32'h000001);
    check("first_busy", last_busy, 2);
    check("first_lu", {31'd0, last_lu}, 32'd0);

    repeat (8) do_req(1, "fill9");
    check("fill9_score", bus.score_o, 32'h000360);
    check("fill9_lines", bus.lines_o, 32'h000009);

    do_req(2, "cross");
    check("cross_score", bus.score_o, 32'h000460);
    check("cross_lines", bus.lines_o, 32'h000011);
    check("cross_level", bus.level_o, 32'h000002);
    check("cross_lu", {31'd0, last_lu}, 32'd1);

    bus.new_game_i = 1'b1;
    tick();
    bus.new_game_i = 1'b0;
    model_reset();
    check("ng_score", bus.score_o, 32'h000000);
    check("ng_lines", bus.lines_o, 32'h000000);
    check("ng_level", bus.level_o, 32'h000001);

    repeat (20) do_req(1, "pre");
    check("pre_score", bus.score_o, 32'h001200);
    check("pre_lines", bus.lines_o, 32'h000020);
    check("pre_level", bus.level_o, 32'h000003);
    do_req(4, "lvl3");
    check("lvl3_score", bus.score_o, 32'h004800);
    check("lvl3_lines", bus.lines_o, 32'h000024);
    check("lvl3_busy", last_busy, 4);

    // Abort during the second SCORE cycle
    bus.lines_en_i  = 1'b1;
    bus.lines_cnt_i = 3'd1;
    tick();
    bus.lines_en_i  = 1'b0;
    tick();
    check("abort_busy", {31'd0, bus.ready_o}, 32'd0);
    bus.new_game_i = 1'b1;
    tick();
    bus.new_game_i = 1'b0;
    model_reset();
    check("abort_score", bus.score_o, 32'h000000);
    check("abort_lines", bus.lines_o, 32'h000000);
    check("abort_level", bus.level_o, 32'h000001);
    check("abort_ready", {31'd0, bus.ready_o}, 32'd1);
    check("abort_done",  {31'd0, bus.done_o}, 32'd0);
    tick();
    check("abort_done2", {31'd0, bus.done_o}, 32'd0);

    bus.new_game_i  = 1'b1;
    bus.lines_en_i  = 1'b1;
    bus.lines_cnt_i = 3'd4;
    tick();
    bus.new_game_i  = 1'b0;
    bus.lines_en_i  = 1'b0;
    check("both_ready", {31'd0, bus.ready_o}, 32'd1);
    tick();
    check("both_ready2", {31'd0, bus.ready_o}, 32'd1);
    check("both_done",   {31'd0, bus.done_o}, 32'd0);
    check("both_score",  bus.score_o, 32'h000000);

    for (int i = 0; i < 3; i++) begin
      bus.lines_en_i  = 1'b1;
      bus.lines_cnt_i = 3'(bad_cnt[i]);
      tick();
      bus.lines_en_i  = 1'b0;
      check("badcnt_ready", {31'd0, bus.ready_o}, 32'd1);
      tick();
      check("badcnt_done",  {31'd0, bus.done_o}, 32'd0);
      check("badcnt_lines", bus.lines_o, 32'h000000);
    end

    // Second request while busy must be dropped
    model_req(1);
    bus.lines_en_i  = 1'b1;
    bus.lines_cnt_i = 3'd1;
    tick();
    bus.lines_cnt_i = 3'd4;
    tick();
    bus.lines_en_i  = 1'b0;
    wait_done("drop");
    check("drop_score", bus.score_o, 32'h000040);
    check("drop_lines", bus.lines_o, 32'h000001);
    tick();
    check("drop_ready", {31'd0, bus.ready_o}, 32'd1);
    check("drop_done",  {31'd0, bus.done_o}, 32'd0);

    guard = 0;
    while (m_level < 20 && guard < 100) begin
      do_req(4, "climb");
      guard++;
    end
    check("climb_level", bus.level_o, 32'h000020);

    repeat (3) begin
      do_req(4, "maxlvl");
      check("maxlvl_lu", {31'd0, last_lu}, 32'd0);
      check("maxlvl_level", bus.level_o, 32'h000020);
    end

    guard = 0;
    while (m_score < 999999 && guard < 100) begin
      do_req(4, "sat");
      guard++;
    end
    check("sat_score", bus.score_o, 32'h999999);
    do_req(4, "sat_hold");
    check("sat_hold_score", bus.score_o, 32'h999999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_stats.md
Name: game_stats

Overview:
- Upstream neighbour of the status-text renderer. Owns score, cleared-lines and level counters for one game.
- Each counter is held as 6 packed BCD digits, so the renderer converts each digit to ASCII by adding '0'. No binary-to-decimal conversion is needed downstream.
- The field-logic FSM drives it with a "lines cleared" event. The block updates the counters over several cycles and reports level-ups so the fall-speed timer can react.

Parameters:
- LINES_PER_LEVEL, 10: lines needed to advance one level (2..15).
- MAX_LEVEL, 20: level saturates here (1..31).
- DIGITS, 6: BCD digits per counter; must match the renderer's number length.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, synchronous, active-low
- new_game_i  in  1  pulse; clears all counters
- lines_en_i  in  1  pulse; lines_cnt_i is valid
- lines_cnt_i  in  3  lines cleared by the last lock, 1..4
- ready_o  out  1  high only in IDLE; a lines_en_i request is accepted only while ready_o=1
- score_o  out  DIGITS*4  BCD score, [DIGITS-1:0][3:0], digit 0 = least significant
- lines_o  out  DIGITS*4  BCD total lines, same layout
- level_o  out  DIGITS*4  BCD level, same layout
- done_o  out  1  one-cycle pulse when an update completes
- level_up_o  out  1  one-cycle pulse, coincident with done_o, when the level incremented

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - score_o = lines_o = 0, level_o = 000001.
  - done_o = level_up_o = 0, ready_o = 1, state = IDLE.
  - Internal registers: level_bin = 1, lvl_lines = 0.
- Score base table, indexed by n = lines_cnt_i, in BCD: 1→000040, 2→000100, 3→000300, 4→001200.
- States: IDLE, SCORE, LINES.
- IDLE:
  - Condition to accept: lines_en_i=1 and 1 ≤ lines_cnt_i ≤ 4.
  - On accept: latch n and iter = level_bin, then go to SCORE.
  - lines_en_i with lines_cnt_i of 0 or 5..7 is ignored; no pulse is generated.
- SCORE:
  - Each cycle: score ← score + base[n], using a BCD add with per-digit decimal carry. Then iter ← iter−1.
  - Leave for LINES after the cycle in which iter reaches 0, giving exactly level_bin add cycles.
  - The multiplier is the pre-update level.
- LINES (single cycle):
  - lines ← lines + n.
  - lvl_lines ← lvl_lines + n.
  - If the sum ≥ LINES_PER_LEVEL:
    - lvl_lines ← sum − LINES_PER_LEVEL.
    - If level_bin < MAX_LEVEL: increment level_bin and level_o (BCD), and assert level_up_o.
    - At MAX_LEVEL the level does not change and level_up_o stays 0.
  - Next state is IDLE.
- done_o / level_up_o are registered and high for the one cycle after the LINES edge, i.e. the first cycle ready_o is back at 1.
- Latency: request accepted at edge k → done_o high in cycle k+level_bin+2. ready_o is low for level_bin+1 cycles.
- lines_en_i while ready_o=0: dropped, no effect. The bench flags this as an upstream protocol error.
- Saturation:
  - Any BCD add whose carry leaves digit DIGITS−1 clamps that counter to all-9s (999999).
  - A saturated counter stays saturated; no wrap-around ever.
- new_game_i:
  - Highest priority, in any state and at any cycle.
  - Next edge gives the reset values, IDLE, and no done_o.
  - An in-flight update is abandoned.
  - Simultaneous new_game_i and lines_en_i: the clear wins and the request is dropped.
- Reset asserted mid-operation behaves the same as new_game_i.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared definitions (alongside game_data_t):
  - bcd_digit_t (4 bits);
  - bcd_num_t ([DIGITS-1:0] of bcd_digit_t);
  - score base-table constants.
- game_data_t's score/lines/level fields are bcd_num_t and are driven directly from this block's outputs.
- One sub-module: bcd_add, combinational.
  - Inputs: DIGITS-digit a and b.
  - Outputs: the sum and a saturate flag.
  - Instantiated twice: score path, and lines/level path (the level is incremented with b = 1).

Test Plan:
- Reset and release → score 000000, lines 000000, level 000001, ready_o=1, done_o=0. Then lines_cnt_i=1 at level 1 → ready_o low 2 cycles, score 000040, lines 000001, done_o pulse, no level_up_o.
- Preload to level 3 (20 lines via twenty single-line events, then lines_cnt_i=4) → exactly 3 SCORE cycles, score increases by 003600, lines 000024, ready_o low 4 cycles.
- Level boundary: at lines 000009, level 1, score S, apply lines_cnt_i=2 → score S+000100 (level-1 multiplier), lines 000011, level 000002, lvl_lines 1, level_up_o pulse coincident with done_o.
- Saturation: drive score to 999960, then lines_cnt_i=1 → score 999999. Another lines_cnt_i=4 → score stays 999999. Separately, at MAX_LEVEL a level crossing → level unchanged, no level_up_o.
- new_game_i asserted in the 2nd SCORE cycle → next cycle all counters at reset values, ready_o=1, no done_o. new_game_i and lines_en_i together → cleared, request ignored.
- Protocol: lines_cnt_i=0 and lines_cnt_i=5 in IDLE → no state change. lines_en_i during busy → dropped, counters reflect only the first request.
